// File: rtl/ysyx_23060025_rd_arbiter_pkg.sv
// Shared FSM states, port identifiers and AXI read-channel constants for the refill read arbiter.
package ysyx_23060025_rd_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AR_I = 3'd1,
    ST_AR_D = 3'd2,
    ST_R_I  = 3'd3,
    ST_R_D  = 3'd4
  } state_t;

  typedef enum logic {
    PORT_INST = 1'b0,
    PORT_DATA = 1'b1
  } port_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;

endpackage

// File: rtl/ysyx_23060025_rr_arb2.sv
// Two-way round-robin grant, combinational from the requests; rr_last updates only when the grant is taken.
// On a tie the port that did not win last time is chosen.
module ysyx_23060025_rr_arb2
  import ysyx_23060025_rd_arbiter_pkg::*;
(
  input  logic clock,
  input  logic rstn,
  input  logic req_i,
  input  logic req_d,
  input  logic take,
  output logic grant_i,
  output logic grant_d
);

  port_t rr_last;

  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if (req_i && req_d) begin
      if (rr_last == PORT_INST) grant_d = 1'b1;
      else                      grant_i = 1'b1;
    end else begin
      grant_i = req_i;
      grant_d = req_d;
    end
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      rr_last <= PORT_INST;
    end else if (take && (grant_i || grant_d)) begin
      rr_last <= grant_d ? PORT_DATA : PORT_INST;
    end
  end

endmodule

// File: rtl/ysyx_23060025_rd_arbiter.sv
// Merges icache and dcache refill reads onto one AXI4 AR/R master, one burst outstanding.
// psel->arvalid 1 cycle; AR held until arready; R beats pass through combinationally with rready=1.
module ysyx_23060025_rd_arbiter
  import ysyx_23060025_rd_arbiter_pkg::*;
#(
  parameter int ADDR_LEN = 32,
  parameter int DATA_LEN = 32
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] inst_paddr,
  input  logic                inst_psel,
  input  logic [7:0]          inst_plen,
  input  logic [2:0]          inst_psize,
  output logic                inst_pvalid,
  output logic                inst_plast,
  output logic [DATA_LEN-1:0] inst_prdata,
  input  logic [ADDR_LEN-1:0] data_praddr,
  input  logic                data_prsel,
  input  logic [7:0]          data_prlen,
  input  logic [2:0]          data_prsize,
  output logic                data_pvalid,
  output logic                data_prlast,
  output logic [DATA_LEN-1:0] data_prdata,
  output logic [ADDR_LEN-1:0] axi_araddr,
  output logic                axi_arvalid,
  input  logic                axi_arready,
  output logic [7:0]          axi_arlen,
  output logic [2:0]          axi_arsize,
  output logic [1:0]          axi_arburst,
  input  logic [DATA_LEN-1:0] axi_rdata,
  input  logic                axi_rvalid,
  output logic                axi_rready,
  input  logic                axi_rlast
);

  state_t state, state_nxt;
  logic   grant_i, grant_d;
  logic   in_idle;

  assign in_idle = (state == ST_IDLE);

  ysyx_23060025_rr_arb2 u_rr_arb2 (
    .clock   (clock),
    .rstn    (rstn),
    .req_i   (inst_psel),
    .req_d   (data_prsel),
    .take    (in_idle),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (grant_d)      state_nxt = ST_AR_D;
        else if (grant_i) state_nxt = ST_AR_I;
      end
      ST_AR_I: if (axi_arready) state_nxt = ST_R_I;
      ST_AR_D: if (axi_arready) state_nxt = ST_R_D;
      // rready is 1 in both R states, so rvalid&rlast is the full handshake
      ST_R_I:  if (axi_rvalid && axi_rlast) state_nxt = ST_IDLE;
      ST_R_D:  if (axi_rvalid && axi_rlast) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      axi_araddr <= '0;
      axi_arlen  <= '0;
      axi_arsize <= '0;
    end else if (in_idle && grant_d) begin
      axi_araddr <= data_praddr;
      axi_arlen  <= data_prlen;
      axi_arsize <= data_prsize;
    end else if (in_idle && grant_i) begin
      axi_araddr <= inst_paddr;
      axi_arlen  <= inst_plen;
      axi_arsize <= inst_psize;
    end
  end

  assign axi_arvalid = (state == ST_AR_I) || (state == ST_AR_D);
  assign axi_rready  = (state == ST_R_I)  || (state == ST_R_D);
  assign axi_arburst = BURST_INCR;

  assign inst_pvalid = (state == ST_R_I) && axi_rvalid;
  assign inst_plast  = (state == ST_R_I) && axi_rvalid && axi_rlast;
  assign data_pvalid = (state == ST_R_D) && axi_rvalid;
  assign data_prlast = (state == ST_R_D) && axi_rvalid && axi_rlast;
  assign inst_prdata = axi_rdata;
  assign data_prdata = axi_rdata;

  // A slave presenting R data outside a granted burst is a fabric bug.
  rvalid_only_in_burst: assert property (@(posedge clock) disable iff (!rstn)
    axi_rvalid |-> axi_rready);

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Directed bench: acts as AXI slave, scoreboards expected AR commands and beat data.
module tb_ysyx_23060025_rd_arbiter;

  logic        clock = 1'b0;
  logic        rstn;
  logic [31:0] inst_paddr, data_praddr, axi_rdata;
  logic        inst_psel, data_prsel;
  logic [7:0]  inst_plen, data_prlen;
  logic [2:0]  inst_psize, data_prsize;
  logic        inst_pvalid, inst_plast, data_pvalid, data_prlast;
  logic [31:0] inst_prdata, data_prdata, axi_araddr;
  logic        axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast;
  logic [7:0]  axi_arlen;
  logic [2:0]  axi_arsize;
  logic [1:0]  axi_arburst;

  ysyx_23060025_rd_arbiter #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
    .clock(clock), .rstn(rstn),
    .inst_paddr(inst_paddr), .inst_psel(inst_psel), .inst_plen(inst_plen), .inst_psize(inst_psize),
    .inst_pvalid(inst_pvalid), .inst_plast(inst_plast), .inst_prdata(inst_prdata),
    .data_praddr(data_praddr), .data_prsel(data_prsel), .data_prlen(data_prlen), .data_prsize(data_prsize),
    .data_pvalid(data_pvalid), .data_prlast(data_prlast), .data_prdata(data_prdata),
    .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
    .axi_rdata(axi_rdata), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rlast(axi_rlast)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic        is_data;
  } ar_t;

  ar_t         ar_q[$];
  logic [31:0] beat_q[$];
  logic        cur_data;
  int          tests = 0;
  int          fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ar_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic d);
    ar_t e;
    e.addr = a; e.len = l; e.size = s; e.is_data = d;
    return e;
  endfunction

  // Called at a negedge; waits for arvalid, checks the command, stalls arready, then handshakes.
  task automatic serve_ar(input int exp_lat, input int stall);
    ar_t e;
    int  n;
    n = 0;
    e = ar_q.pop_front();
    cur_data = e.is_data;
    do begin
      @(negedge clock);
      n++;
    end while (!axi_arvalid && n < 20);
    chk("ar_latency", n, exp_lat);
    chk("araddr", axi_araddr, e.addr);
    chk("arlen", axi_arlen, e.len);
    chk("arsize", axi_arsize, e.size);
    chk("arburst", axi_arburst, 2'b01);
    repeat (stall) begin
      @(negedge clock);
      chk("stall_arvalid", axi_arvalid, 1);
      chk("stall_araddr", axi_araddr, e.addr);
      chk("stall_arlen", axi_arlen, e.len);
      chk("stall_rready", axi_rready, 0);
    end
    axi_arready = 1'b1;
    @(negedge clock);
    axi_arready = 1'b0;
    chk("r_rready", axi_rready, 1);
    chk("r_arvalid", axi_arvalid, 0);
  endtask

  // Drives n beats (optional 1,0,0,1 style gaps); ends one negedge after the last beat.
  task automatic run_beats(input int n, input bit gaps);
    int cnt;
    cnt = 0;
    for (int b = 0; b < n; b++) begin
      if (gaps && (b % 2 == 1)) begin
        repeat (2) begin
          axi_rvalid = 1'b0; axi_rlast = 1'b0;
          #1;
          chk("gap_pvalid", {inst_pvalid, data_pvalid}, 2'b00);
          @(negedge clock);
        end
      end
      axi_rvalid = 1'b1;
      axi_rdata  = $urandom;
      axi_rlast  = (b == n - 1);
      beat_q.push_back(axi_rdata);
      #1;
      if (cur_data ? data_pvalid : inst_pvalid) begin
        cnt++;
        chk("prdata", cur_data ? data_prdata : inst_prdata, beat_q.pop_front());
      end
      chk("plast", cur_data ? data_prlast : inst_plast, (b == n - 1));
      chk("other_pvalid", cur_data ? inst_pvalid : data_pvalid, 0);
      @(negedge clock);
    end
    axi_rvalid = 1'b0; axi_rlast = 1'b0;
    #1;
    chk("beat_count", cnt, n);
    chk("idle_rready", axi_rready, 0);
    chk("idle_arvalid", axi_arvalid, 0);
    chk("idle_pvalid", {inst_pvalid, data_pvalid}, 2'b00);
    beat_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    inst_paddr = 32'h3000_0000; inst_psel = 0; inst_plen = 8'd3; inst_psize = 3'd2;
    data_praddr = 32'h8000_1000; data_prsel = 0; data_prlen = 8'd3; data_prsize = 3'd2;
    axi_arready = 0; axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0;
    cur_data = 0;
    #1;
    chk("rst_arvalid", axi_arvalid, 0);
    chk("rst_rready", axi_rready, 0);
    chk("rst_araddr", axi_araddr, 0);
    chk("rst_arlen_size", {axi_arlen, axi_arsize}, 0);
    chk("rst_pvalid", {inst_pvalid, inst_plast, data_pvalid, data_prlast}, 0);
    repeat (2) @(negedge clock);
    rstn = 1'b1;
    @(negedge clock);

    // 1: icache alone
    inst_psel = 1;
    ar_q.push_back(mk(32'h3000_0000, 8'd3, 3'd2, 1'b0));
    serve_ar(1, 0);
    run_beats(4, 0);
    inst_psel = 0;
    @(negedge clock);

    // 2: simultaneous requests, dcache wins first, one IDLE cycle between bursts
    inst_psel = 1; data_prsel = 1;
    ar_q.push_back(mk(32'h8000_1000, 8'd3, 3'd2, 1'b1));
    ar_q.push_back(mk(32'h3000_0000, 8'd3, 3'd2, 1'b0));
    serve_ar(1, 0);
    run_beats(4, 0);
    data_prsel = 0;
    serve_ar(1, 0);
    run_beats(4, 0);
    inst_psel = 0;
    @(negedge clock);

    // 3: arready stalled 5 cycles
    inst_paddr = 32'h3000_0040; inst_plen = 8'd1; inst_psel = 1;
    ar_q.push_back(mk(32'h3000_0040, 8'd1, 3'd2, 1'b0));
    serve_ar(1, 5);
    run_beats(2, 0);
    inst_psel = 0;
    @(negedge clock);

    // 4: both requesting for four bursts alternate D,I,D,I
    inst_psel = 1; data_prsel = 1;
    for (int k = 0; k < 4; k++)
      ar_q.push_back((k % 2 == 0) ? mk(32'h8000_1000, 8'd3, 3'd2, 1'b1)
                                  : mk(32'h3000_0040, 8'd1, 3'd2, 1'b0));
    for (int k = 0; k < 4; k++) begin
      serve_ar(1, 0);
      run_beats((k % 2 == 0) ? 4 : 2, 0);
      if (k == 3) begin inst_psel = 0; data_prsel = 0; end
    end
    @(negedge clock);

    // 6: plen 7 with rvalid gaps
    inst_paddr = 32'h3000_0100; inst_plen = 8'd7; inst_psel = 1;
    ar_q.push_back(mk(32'h3000_0100, 8'd7, 3'd2, 1'b0));
    serve_ar(1, 0);
    run_beats(8, 1);
    inst_psel = 0;
    @(negedge clock);

    // 5: reset in the middle of an icache burst
    inst_paddr = 32'h3000_0200; inst_plen = 8'd3; inst_psel = 1;
    ar_q.push_back(mk(32'h3000_0200, 8'd3, 3'd2, 1'b0));
    serve_ar(1, 0);
    axi_rvalid = 1; axi_rdata = 32'hCAFE_0001; axi_rlast = 0;
    #1;
    chk("pre_rst_pvalid", inst_pvalid, 1);
    rstn = 0;
    #1;
    chk("midrst_arvalid_rready", {axi_arvalid, axi_rready}, 0);
    chk("midrst_pvalid", {inst_pvalid, inst_plast, data_pvalid, data_prlast}, 0);
    chk("midrst_araddr", axi_araddr, 0);
    axi_rvalid = 0; inst_psel = 0; data_prsel = 1;
    data_praddr = 32'h8000_2000; data_prlen = 8'd1; data_prsize = 3'd2;
    ar_q.push_back(mk(32'h8000_2000, 8'd1, 3'd2, 1'b1));
    @(negedge clock);
    rstn = 1;
    serve_ar(1, 0);
    run_beats(2, 0);
    data_prsel = 0;
    @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
